// File: rtl/switch_out_arbiter.sv
// ----------------------------------------------------------------------------
// switch_out_arbiter
//
// Egress stage for one output port of a 4-port switch. Up to NUM_SRC input
// FIFOs present a head packet that targets this port. Each cycle one of them
// is picked by round-robin and popped. The chosen packet is loaded into a
// one-entry output register that drives out_valid/out_pkt under out_ready
// backpressure. A saturating counter per source records how many packets
// were forwarded from that source.
//
// Ports
//   clk        clock, sole domain
//   rst        synchronous, active-high reset
//   req        req[i]: FIFO i is non-empty and its head targets this port
//   req_pkt    head packet of FIFO i at [i*PKT_W +: PKT_W]
//   pop        one-hot, combinational; dequeues the winning FIFO this cycle
//   out_valid  output register holds a packet
//   out_pkt    packet held in the output register
//   out_ready  sink takes out_pkt on the edge when out_valid & out_ready
//   fwd_cnt    forwarded-packet count of source i at [i*CNT_W +: CNT_W]
// ----------------------------------------------------------------------------
module switch_out_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned PKT_W   = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [NUM_SRC*PKT_W-1:0] req_pkt,
    output logic [NUM_SRC-1:0]       pop,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_pkt,
    input  logic                     out_ready,
    output logic [NUM_SRC*CNT_W-1:0] fwd_cnt
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // The FSM state is the output-register occupancy, so out_valid is the state bit.
    localparam logic StEmpty = 1'b0;
    localparam logic StFull  = 1'b1;

    // Pointer resets to the last source so that source 0 is scanned first.
    localparam logic [PTR_W-1:0] PtrReset = PTR_W'(NUM_SRC - 1);

    logic             state_q;
    logic             state_d;
    logic [PKT_W-1:0] pkt_q;
    logic [PTR_W-1:0] rr_ptr_q;

    logic             any_req;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] cand;
    logic             can_load;
    logic             load;

    logic [PKT_W-1:0] pkt_arr [NUM_SRC];

    // ------------------------------------------------------------------------
    // Round-robin grant: first requester after rr_ptr, wrapping around.
    // ------------------------------------------------------------------------
    always_comb begin
        any_req = 1'b0;
        winner  = rr_ptr_q;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    // The register can take a new packet when it is empty or being drained now.
    assign can_load = (state_q == StEmpty) || out_ready;
    assign load     = can_load && any_req;

    // Pop is suppressed during reset so the FIFO loses no entry.
    always_comb begin
        pop = '0;
        if (load && !rst) begin
            pop[winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: begin
                if (any_req) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // Drained with nothing to refill goes empty; refill keeps it full
                // with no bubble; a stall holds the packet.
                if (out_ready && !any_req) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            pkt_q    <= '0;
            rr_ptr_q <= PtrReset;
        end else begin
            state_q <= state_d;
            if (load) begin
                pkt_q    <= pkt_arr[winner];
                rr_ptr_q <= winner;
            end
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_pkt   = pkt_q;

    // ------------------------------------------------------------------------
    // Per-source packet slicing and saturating forwarded counters
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [CNT_W-1:0] cnt_q;

        assign pkt_arr[i] = req_pkt[i*PKT_W +: PKT_W];

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (load && (winner == PTR_W'(i)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign fwd_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_switch_out_arbiter.sv
// ----------------------------------------------------------------------------
// tb_switch_out_arbiter
//
// Drives two instances of switch_out_arbiter from the same stimulus: one with
// the default 16-bit counters and one with 2-bit counters for saturation.
// A behavioural model (pointer, occupancy flag, held packet, unbounded
// per-source counts) is compared with both instances every cycle; directed
// literal checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_switch_out_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 16;
    localparam int CS = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_pkt;
    logic           out_ready;

    logic [N-1:0]    pop, pop_s;
    logic            out_valid, out_valid_s;
    logic [W-1:0]    out_pkt, out_pkt_s;
    logic [N*CW-1:0] fwd_cnt;
    logic [N*CS-1:0] fwd_cnt_s;

    int n_vec = 0;
    int n_err = 0;
    int seq   = 0;

    // Model state
    bit          m_known = 1'b0;
    bit          m_valid;
    logic [W-1:0] m_pkt;
    int          m_ptr;
    int          m_cnt [N];

    always #5 clk = ~clk;

    switch_out_arbiter #(.NUM_SRC(N), .PKT_W(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_pkt   (req_pkt),
        .pop       (pop),
        .out_valid (out_valid),
        .out_pkt   (out_pkt),
        .out_ready (out_ready),
        .fwd_cnt   (fwd_cnt)
    );

    switch_out_arbiter #(.NUM_SRC(N), .PKT_W(W), .CNT_W(CS)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_pkt   (req_pkt),
        .pop       (pop_s),
        .out_valid (out_valid_s),
        .out_pkt   (out_pkt_s),
        .out_ready (out_ready),
        .fwd_cnt   (fwd_cnt_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int first_req(input int ptr, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic longint capped(input int c, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (c > mx) ? mx : longint'(c);
    endfunction

    // ------------------------------------------------------------------------
    // Compare, then advance the model with the inputs the next edge will see.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        int          w;
        logic [N-1:0] e_pop;
        w     = first_req(m_ptr, req);
        e_pop = '0;
        if (m_known) begin
            if (!rst && (!m_valid || out_ready) && w >= 0) e_pop[w] = 1'b1;
            chk("model pop", 64'(pop), 64'(e_pop));
            chk("model pop_sat", 64'(pop_s), 64'(e_pop));
            chk("model out_valid", 64'(out_valid), 64'(m_valid));
            chk("model out_valid_sat", 64'(out_valid_s), 64'(m_valid));
            chk("model out_pkt", 64'(out_pkt), 64'(m_pkt));
            chk("model out_pkt_sat", 64'(out_pkt_s), 64'(m_pkt));
            for (int i = 0; i < N; i++) begin
                chk($sformatf("model fwd_cnt[%0d]", i), 64'(fwd_cnt[i*CW +: CW]),
                    64'(capped(m_cnt[i], CW)));
                chk($sformatf("model fwd_cnt_sat[%0d]", i), 64'(fwd_cnt_s[i*CS +: CS]),
                    64'(capped(m_cnt[i], CS)));
            end
        end
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_pkt   = '0;
            m_ptr   = N - 1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_known && (!m_valid || out_ready)) begin
            if (w >= 0) begin
                m_valid  = 1'b1;
                m_pkt    = req_pkt[w*W +: W];
                m_ptr    = w;
                m_cnt[w] = m_cnt[w] + 1;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        req       = rq;
        out_ready = rdy;
        seq++;
        for (int i = 0; i < N; i++) req_pkt[i*W +: W] = {4'(i), 4'hC, 8'(seq)};
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        req_pkt   = '0;

        // Reset held with all sources requesting
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b1111, 1'b1);
            settle();
            chk("reset pop", 64'(pop), 64'h0);
            chk("reset out_valid", 64'(out_valid), 64'h0);
            chk("reset fwd_cnt", 64'(fwd_cnt), 64'h0);
        end

        // Round-robin over all four sources, source 0 first
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b1111, 1'b1);
            settle();
            chk($sformatf("rr pop %0d", k), 64'(pop), 64'(1 << (k % 4)));
            if (k > 0) chk($sformatf("rr out_valid %0d", k), 64'(out_valid), 64'h1);
        end
        step(1'b0, 4'b0000, 1'b1);
        settle();
        for (int i = 0; i < N; i++)
            chk($sformatf("rr fwd_cnt[%0d]", i), 64'(fwd_cnt[i*CW +: CW]), 64'd2);

        // Sparse requesters alternate 1,3,1,3
        step(1'b1, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b1010, 1'b1);
            settle();
            chk($sformatf("sparse pop %0d", k), 64'(pop),
                (k % 2 == 0) ? 64'b0010 : 64'b1000);
        end
        step(1'b0, 4'b0000, 1'b1);
        settle();
        chk("sparse fwd_cnt[0]", 64'(fwd_cnt[0*CW +: CW]), 64'd0);
        chk("sparse fwd_cnt[1]", 64'(fwd_cnt[1*CW +: CW]), 64'd2);
        chk("sparse fwd_cnt[2]", 64'(fwd_cnt[2*CW +: CW]), 64'd0);
        chk("sparse fwd_cnt[3]", 64'(fwd_cnt[3*CW +: CW]), 64'd2);

        // Backpressure: hold A5A5 for 5 stalled cycles, then release
        step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        req_pkt[2*W +: W] = 16'hA5A5;
        settle();
        chk("bp first pop", 64'(pop), 64'b0100);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0100, 1'b0);
            req_pkt[2*W +: W] = 16'h5A5A;
            settle();
            chk($sformatf("bp hold pkt %0d", k), 64'(out_pkt), 64'hA5A5);
            chk($sformatf("bp hold pop %0d", k), 64'(pop), 64'h0);
        end
        step(1'b0, 4'b0100, 1'b1);
        req_pkt[2*W +: W] = 16'h5A5A;
        settle();
        chk("bp release pop", 64'(pop), 64'b0100);
        chk("bp release pkt", 64'(out_pkt), 64'hA5A5);
        step(1'b0, 4'b0000, 1'b1);
        settle();
        chk("bp next pkt", 64'(out_pkt), 64'h5A5A);

        // Drain a single packet
        step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        req_pkt[2*W +: W] = 16'h1234;
        step(1'b0, 4'b0000, 1'b1);
        settle();
        chk("drain valid", 64'(out_valid), 64'h1);
        chk("drain pkt", 64'(out_pkt), 64'h1234);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 4'b0000, 1'b1);
            settle();
            chk($sformatf("drain empty %0d", k), 64'(out_valid), 64'h0);
        end

        // Saturation on the 2-bit instance, then a reset pulse mid-stream
        step(1'b1, 4'b0000, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        settle();
        chk("sat fwd_cnt_sat[0]", 64'(fwd_cnt_s[0 +: CS]), 64'd3);
        chk("sat fwd_cnt[0]", 64'(fwd_cnt[0 +: CW]), 64'd6);
        for (int k = 0; k < 2; k++) step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0001, 1'b0);
        settle();
        chk("sat stays 3", 64'(fwd_cnt_s[0 +: CS]), 64'd3);
        chk("sat wide 8", 64'(fwd_cnt[0 +: CW]), 64'd8);
        step(1'b1, 4'b0001, 1'b1);
        settle();
        chk("rst pulse pop", 64'(pop), 64'h0);
        step(1'b0, 4'b0000, 1'b0);
        settle();
        chk("rst pulse cnt_sat", 64'(fwd_cnt_s), 64'h0);
        chk("rst pulse cnt", 64'(fwd_cnt), 64'h0);
        chk("rst pulse valid", 64'(out_valid), 64'h0);

        // Mixed requests and backpressure, checked by the model
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'((i * 7 + 3) % 16), (i % 3) != 0);
        end

        step(1'b0, 4'b0000, 1'b1);
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
